// File: rtl/comp_share_arb_if.sv
// rtl/comp_share_arb_if.sv - requester-side bundle for the shared comparator arbiter
//
// Purpose: groups the per-requester request/operand buses and the shared
// result/acknowledge signals of comp_share_arb.
// Signals:
//   req    [NREQ]            request level per requester
//   a_bus  [NREQ*DATAWIDTH]  operand a, requester i at [i*DATAWIDTH +: DATAWIDTH]
//   b_bus  [NREQ*DATAWIDTH]  operand b, same packing
//   ack    [NREQ]            one-hot acknowledge, result valid while high
//   owner  [3]               current or last granted requester
//   busy                     arbiter not idle
//   gt/lt/eq                 registered flags of the last completed compare
// Modports: master = requester side, slave = arbiter side.
interface comp_share_arb_if #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4
) ();
    logic [NREQ-1:0]           req;
    logic [NREQ*DATAWIDTH-1:0] a_bus;
    logic [NREQ*DATAWIDTH-1:0] b_bus;
    logic [NREQ-1:0]           ack;
    logic [2:0]                owner;
    logic                      busy;
    logic                      gt;
    logic                      lt;
    logic                      eq;

    modport master (
        output req, a_bus, b_bus,
        input  ack, owner, busy, gt, lt, eq
    );

    modport slave (
        input  req, a_bus, b_bus,
        output ack, owner, busy, gt, lt, eq
    );
endinterface

// File: rtl/comp_share_arb.sv
// rtl/comp_share_arb.sv - round-robin arbiter sharing one unsigned comparator
//
// Purpose: grants one requester at a time, latches its operands, evaluates a
// single gt/lt/eq comparator and returns the result with a four-phase req/ack
// handshake.
// Ports:
//   Clk  in   clock, rising edge
//   Rst  in   synchronous active-high reset
//   bus  slave modport of comp_share_arb_if (req, a_bus, b_bus in;
//        ack, owner, busy, gt, lt, eq out)
module comp_share_arb #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    comp_share_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [NREQ-1:0]        r_ack;
    logic [2:0]             r_owner;
    logic [2:0]             r_last;
    logic                   r_busy;
    logic                   r_gt;
    logic                   r_lt;
    logic                   r_eq;
    logic [DATAWIDTH-1:0]   r_a;
    logic [DATAWIDTH-1:0]   r_b;

    state_t                 w_next_state;
    logic [NREQ-1:0]        w_ack;
    logic [2:0]             w_owner;
    logic [2:0]             w_last;
    logic                   w_busy;
    logic                   w_gt;
    logic                   w_lt;
    logic                   w_eq;
    logic [DATAWIDTH-1:0]   w_a;
    logic [DATAWIDTH-1:0]   w_b;

    logic                   w_found;
    logic [2:0]             w_win;
    int                     w_idx;
    logic [DATAWIDTH-1:0]   w_a_sel;
    logic [DATAWIDTH-1:0]   w_b_sel;
    logic [NREQ-1:0]        w_owner_1h;
    logic                   w_owner_req;

    // Round-robin winner: scan last+1, last+2, ... wrapping modulo NREQ; the
    // first requester found with req high wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = int'(r_last) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && (((bus.req >> w_idx) & NREQ'(1)) != '0)) begin
                w_found = 1'b1;
                w_win   = 3'(w_idx);
            end
        end
    end

    // Operand mux for the winner; shifting the packed bus avoids a variable
    // part-select.
    assign w_a_sel = DATAWIDTH'(bus.a_bus >> (int'(w_win) * DATAWIDTH));
    assign w_b_sel = DATAWIDTH'(bus.b_bus >> (int'(w_win) * DATAWIDTH));

    assign w_owner_1h  = NREQ'(1) << r_owner;
    assign w_owner_req = |(bus.req & w_owner_1h);

    always_comb begin
        w_next_state = r_state;
        w_ack        = r_ack;
        w_owner      = r_owner;
        w_last       = r_last;
        w_gt         = r_gt;
        w_lt         = r_lt;
        w_eq         = r_eq;
        w_a          = r_a;
        w_b          = r_b;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_owner      = w_win;
                    w_a          = w_a_sel;
                    w_b          = w_b_sel;
                    w_next_state = S_EVAL;
                end
            end
            S_EVAL: begin
                // The single shared comparator only ever sees latched operands.
                w_gt         = (r_a >  r_b);
                w_lt         = (r_a <  r_b);
                w_eq         = (r_a == r_b);
                w_ack        = w_owner_1h;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                // An owner that already dropped req still gets a one-cycle ack.
                if (!w_owner_req) begin
                    w_ack        = '0;
                    w_last       = r_owner;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_ack        = '0;
                w_next_state = S_IDLE;
            end
        endcase
        w_busy = (w_next_state != S_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_ack   <= '0;
            r_owner <= '0;
            r_last  <= 3'(NREQ - 1);
            r_busy  <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_next_state;
            r_ack   <= w_ack;
            r_owner <= w_owner;
            r_last  <= w_last;
            r_busy  <= w_busy;
            r_gt    <= w_gt;
            r_lt    <= w_lt;
            r_eq    <= w_eq;
            r_a     <= w_a;
            r_b     <= w_b;
        end
    end

    assign bus.ack   = r_ack;
    assign bus.owner = r_owner;
    assign bus.busy  = r_busy;
    assign bus.gt    = r_gt;
    assign bus.lt    = r_lt;
    assign bus.eq    = r_eq;

endmodule

// File: doc/comp_share_arb.md
# comp_share_arb

Round-robin arbiter and sequencer that shares one unsigned magnitude comparator (gt/lt/eq) among `NREQ` requesters in the scheduled datapath. Each requester presents two operands and a request. The block grants one requester at a time, latches its operands, and registers the comparison flags. It then returns the result with a four-phase req/ack handshake. Downstream FSMs use it so that several comparison operations in one schedule need only one comparator instance.

## Interface
- `DATAWIDTH`, default 8: operand width in bits; operands are unsigned.
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `Clk`  in  1: clock; everything updates on the rising edge.
- `Rst`  in  1: synchronous, active-high reset.
- `req`  in  NREQ: per-requester request level.
- `a_bus`  in  NREQ*DATAWIDTH: operand a; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH].
- `b_bus`  in  NREQ*DATAWIDTH: operand b, same packing as `a_bus`.
- `ack`  out  NREQ: one-hot acknowledge; result is valid while asserted.
- `owner`  out  3: index of the current or last granted requester.
- `busy`  out  1: high in every state except IDLE.
- `gt`, `lt`, `eq`  out  1 each: registered comparison flags of the last completed operation.

## Operation
- FSM states and transitions (all outputs registered):
  - **IDLE**: if `req` != 0, grant the winner (see round-robin below), latch its a/b into operand registers, load `owner`, go to EVAL. Otherwise stay in IDLE.
  - **EVAL**: the shared comparator evaluates the latched operands. Register gt/lt/eq, set `ack[owner]`=1, go to DONE.
  - **DONE**: hold `ack[owner]` while `req[owner]`=1. On an edge where `req[owner]`=0, clear `ack` and go to IDLE.
- Round-robin arbitration:
  - Search starts at `last+1` and wraps modulo NREQ.
  - `last` updates to `owner` on DONE->IDLE.
  - Reset sets `last`=NREQ-1, so requester 0 has top priority first.
- Flags:
  - Exactly one of gt/lt/eq is 1 after the first completed operation.
  - Unsigned compare: a>b sets gt, a<b sets lt, a==b sets eq.
  - Flags hold their value until the next EVAL->DONE.
- Operand capture:
  - Operands are sampled only on the IDLE->EVAL edge.
  - Changes to `a_bus`/`b_bus` after that edge have no effect on the result.
- Requester obligations:
  - Hold `req` high until `ack` is seen, then drop `req`.
  - Do not re-raise `req` until `ack` has fallen.
- Requests that arrive while `busy`=1 wait; they are not lost, since `req` is level-sensitive.
- If `req[owner]` drops before DONE is reached, the operation still completes. `ack` pulses for exactly one cycle, because DONE sees req=0 on its first edge.
- Reset values: state=IDLE, `ack`=0, `busy`=0, `owner`=0, gt=lt=eq=0, `last`=NREQ-1, operand registers 0.
- `Rst` asserted in any state:
  - Returns the block to the reset values on that edge.
  - Any in-flight operation is discarded with no `ack`.
  - `Rst` has priority over every transition.

## Timing
- Request sampled high in IDLE at edge k:
  - Edge k: IDLE->EVAL.
  - Edge k+1: flags and `ack` valid.
  - Acknowledge latency is 2 edges.
- `ack` falls on the first edge at which the owner's `req` is 0. IDLE is re-entered on that same edge.
- Next grant occurs at the earliest one edge after that.
- Minimum period per operation: 3 cycles, when the requester drops `req` the cycle after seeing `ack`.
- `busy` rises on edge k and falls on the DONE->IDLE edge.
- `owner` is stable from edge k until the next grant.

## Test plan
- **Reset:** hold `Rst` for 2 cycles with random `req`/bus values. Required: ack=0, busy=0, owner=0, gt=lt=eq=0, state IDLE.
- **Single request, gt:** req=0010, requester 1 a=0x50, b=0x30. Required: ack=0010 exactly 2 edges after req is sampled, owner=1, gt=1 lt=0 eq=0. When req drops, ack clears on the next edge and busy=0.
- **Flag cases and operand capture:** requester 0 with a=b=0xFF gives eq=1. Then a=0x00, b=0xFF gives lt=1. Changing a to 0xFF during EVAL must not alter the result (lt stays 1).
- **Simultaneous requests after reset:** req=1111, each requester releasing one cycle after its ack. Required: acks in order 0,1,2,3, each with its own correct flags.
- **Fairness:** req[0] and req[2] re-asserted immediately after each release. Required: grants alternate 0,2,0,2; neither requester is granted twice in a row while the other waits.
- **Reset mid-operation:** req=0100, assert `Rst` on the edge the block is in EVAL. Required: no ack ever pulses for requester 2, outputs return to reset values. With req=0101 after reset, requester 0 is granted first.
